program_loader: RTL and testbench

PROGRAM_LOADER -- requirements
Module: program_loader

---
 rtl/program_loader_pkg.sv | 16 +
 rtl/program_loader_prog_ram.sv | 22 ++
 rtl/program_loader.sv | 106 ++++++++++
 tb/tb_program_loader.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/program_loader_pkg.sv
// Shared CPU-side definitions: loader state encoding and protocol constants.
package program_loader_pkg;

  typedef enum logic [1:0] {
    LOAD_LO = 2'd0,
    LOAD_HI = 2'd1,
    WRITE   = 2'd2,
    RUN     = 2'd3
  } load_state_t;

  // A word of all zeros terminates a program image.
  localparam logic [15:0] HALT_WORD  = 16'h0000;
  // ASCII 'R' received while running restarts the load.
  localparam logic [7:0]  RELOAD_CMD = 8'h52;

endpackage

// File: rtl/program_loader_prog_ram.sv
// Program store: one write port, one registered read port, no reset.
module prog_ram #(
  parameter int ADDR_BITS  = 11,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_BITS-1:0]  waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_BITS-1:0]  raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_BITS];

  // Write port and synchronous read; contents survive reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/program_loader.sv
// Serial program loader: assembles byte pairs into instruction words, fills
// the program RAM, then releases the CPU and serves instruction fetches.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int ADDR_BITS  = 11,
  parameter int DATA_WIDTH = 16   // byte assembly is only defined for 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  input  logic [ADDR_BITS-1:0]  addr_program,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  cpu_reset,
  output logic                  load_done,
  output logic [ADDR_BITS:0]    word_count
);

  load_state_t           state, state_nx;
  logic [7:0]            lo_q, hi_q;
  logic [ADDR_BITS-1:0]  wr_ptr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] ram_q;
  logic                  we;
  logic                  last_addr;
  logic                  reload;

  assign wdata     = DATA_WIDTH'({hi_q, lo_q});
  assign we        = (state == WRITE);
  assign last_addr = (wr_ptr == '1);
  assign reload    = (state == RUN) && rx_valid && (rx_data == RELOAD_CMD);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= LOAD_LO;
    else        state <= state_nx;
  end

  // Next-state logic; strobes during WRITE fall through unobserved.
  always_comb begin
    state_nx = state;
    case (state)
      LOAD_LO: if (rx_valid) state_nx = LOAD_HI;
      LOAD_HI: if (rx_valid) state_nx = WRITE;
      WRITE:   state_nx = ((wdata == DATA_WIDTH'(HALT_WORD)) || last_addr) ? RUN : LOAD_LO;
      RUN:     if (reload) state_nx = LOAD_LO;
      default: state_nx = LOAD_LO;
    endcase
  end

  // Byte assembly registers; reset discards a half-built word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lo_q <= '0;
      hi_q <= '0;
    end else begin
      if (state == LOAD_LO && rx_valid) lo_q <= rx_data;
      if (state == LOAD_HI && rx_valid) hi_q <= rx_data;
    end
  end

  // Write pointer saturates at the top address so it never wraps; the
  // word count is one bit wider so a full image reads 2^ADDR_BITS.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      word_count <= '0;
    end else if (reload) begin
      wr_ptr     <= '0;
      word_count <= '0;
    end else if (we) begin
      if (!last_addr) wr_ptr <= wr_ptr + 1'b1;
      word_count <= word_count + 1'b1;
    end
  end

  // CPU handshake flags registered from the next state so they track
  // (state == RUN) exactly.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cpu_reset <= 1'b1;
      load_done <= 1'b0;
    end else begin
      cpu_reset <= (state_nx != RUN);
      load_done <= (state_nx == RUN);
    end
  end

  // Fetch data is masked to zero outside RUN; load_done is the registered
  // RUN flag, so the mask also clears asynchronously on reset.
  assign data = load_done ? ram_q : '0;

  prog_ram #(
    .ADDR_BITS (ADDR_BITS),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_ram (
    .clk  (clk),
    .we   (we),
    .waddr(wr_ptr),
    .wdata(wdata),
    .raddr(addr_program),
    .rdata(ram_q)
  );

endmodule

// File: tb/tb_program_loader.sv
// Directed bench: default-size loader plus a 3-bit address loader for the
// full-memory boundary.
module tb_program_loader;

  logic        clk = 1'b0;
  logic        rst_a, rst_b;
  logic [7:0]  rx_data_a, rx_data_b;
  logic        rx_valid_a, rx_valid_b;
  logic [10:0] addr_a;
  logic [2:0]  addr_b;
  logic [15:0] data_a, data_b;
  logic        cpu_reset_a, cpu_reset_b, load_done_a, load_done_b;
  logic [11:0] wc_a;
  logic [3:0]  wc_b;

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  program_loader dut_a (
    .clk(clk), .reset(rst_a), .rx_data(rx_data_a), .rx_valid(rx_valid_a),
    .addr_program(addr_a), .data(data_a), .cpu_reset(cpu_reset_a),
    .load_done(load_done_a), .word_count(wc_a)
  );

  program_loader #(.ADDR_BITS(3)) dut_b (
    .clk(clk), .reset(rst_b), .rx_data(rx_data_b), .rx_valid(rx_valid_b),
    .addr_program(addr_b), .data(data_b), .cpu_reset(cpu_reset_b),
    .load_done(load_done_b), .word_count(wc_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One-cycle strobe, then 'gap' extra idle cycles; returns on a negedge.
  task automatic send(input bit which, input logic [7:0] b, input int gap);
    @(negedge clk);
    if (which) begin rx_valid_b = 1'b1; rx_data_b = b; end
    else       begin rx_valid_a = 1'b1; rx_data_a = b; end
    @(negedge clk);
    rx_valid_a = 1'b0;
    rx_valid_b = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic rd(input bit which, input int a, output logic [15:0] d);
    @(negedge clk);
    if (which) addr_b = a[2:0];
    else       addr_a = a[10:0];
    @(negedge clk);
    d = which ? data_b : data_a;
  endtask

  logic [15:0] d;

  initial begin
    rst_a = 1'b0; rst_b = 1'b0;
    rx_valid_a = 1'b0; rx_valid_b = 1'b0;
    rx_data_a = '0; rx_data_b = '0;
    addr_a = '0; addr_b = '0;
    repeat (3) @(negedge clk);
    chk("rst cpu_reset", cpu_reset_a, 1);
    chk("rst load_done", load_done_a, 0);
    chk("rst word_count", wc_a, 0);
    chk("rst data", data_a, 0);
    rst_a = 1'b1; rst_b = 1'b1;

    // Two-word image terminated by the halt word, bytes 4 cycles apart.
    send(0, 8'h34, 2);
    send(0, 8'h12, 2);
    send(0, 8'h00, 2);
    send(0, 8'h00, 0);
    chk("in WRITE load_done", load_done_a, 0);
    chk("in WRITE cpu_reset", cpu_reset_a, 1);
    @(negedge clk);
    chk("run load_done", load_done_a, 1);
    chk("run cpu_reset", cpu_reset_a, 0);
    chk("run word_count", wc_a, 2);
    rd(0, 0, d); chk("mem0", d, 16'h1234);
    rd(0, 1, d); chk("mem1", d, 16'h0000);

    // Non-reload byte in RUN is ignored.
    send(0, 8'h11, 1);
    chk("ignore byte load_done", load_done_a, 1);
    rd(0, 0, d); chk("ignore byte mem0", d, 16'h1234);

    // Reload command.
    send(0, 8'h52, 0);
    chk("reload cpu_reset", cpu_reset_a, 1);
    chk("reload load_done", load_done_a, 0);
    chk("reload word_count", wc_a, 0);
    chk("reload data", data_a, 0);

    // Reload image, with a stray strobe landing in the WRITE cycle.
    send(0, 8'hAB, 2);
    send(0, 8'hCD, 0);
    rx_valid_a = 1'b1; rx_data_a = 8'h77;
    @(negedge clk);
    rx_valid_a = 1'b0;
    chk("after WRITE word_count", wc_a, 1);
    send(0, 8'h00, 1);
    send(0, 8'h00, 0);
    @(negedge clk);
    chk("reload run load_done", load_done_a, 1);
    chk("reload run word_count", wc_a, 2);
    rd(0, 0, d); chk("reload mem0", d, 16'hCDAB);
    rd(0, 1, d); chk("reload mem1", d, 16'h0000);

    // Reset between low and high byte of the second word.
    send(0, 8'h52, 1);
    send(0, 8'h11, 1);
    send(0, 8'h22, 2);
    chk("pre-abort word_count", wc_a, 1);
    send(0, 8'h33, 1);
    rst_a = 1'b0;
    #2;
    chk("abort word_count", wc_a, 0);
    chk("abort cpu_reset", cpu_reset_a, 1);
    @(negedge clk);
    rst_a = 1'b1;
    send(0, 8'h44, 1);
    send(0, 8'h55, 1);
    send(0, 8'h00, 1);
    send(0, 8'h00, 1);
    chk("abort run load_done", load_done_a, 1);
    chk("abort run word_count", wc_a, 2);
    rd(0, 0, d); chk("abort mem0", d, 16'h5544);

    // Small memory filled completely at minimum byte spacing.
    for (int i = 1; i <= 8; i++) begin
      send(1, i[7:0], 0);
      send(1, i[7:0], (i == 8) ? 0 : 1);
    end
    @(negedge clk);
    chk("full load_done", load_done_b, 1);
    chk("full cpu_reset", cpu_reset_b, 0);
    chk("full word_count", wc_b, 8);
    send(1, 8'hEE, 1);
    send(1, 8'hEE, 1);
    chk("full extra word_count", wc_b, 8);
    rd(1, 0, d); chk("full mem0", d, 16'h0101);
    rd(1, 7, d); chk("full mem7", d, 16'h0808);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
